mrv1_wb_arb: RTL and testbench

MRV1_WB_ARB -- requirements
Module: mrv1_wb_arb

---
 rtl/mrv1_wb_arb.sv | 142 ++++++++++++++
 tb/tb_mrv1_wb_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mrv1_wb_arb.sv
// mrv1_wb_arb: writeback arbiter for the multithreaded exec cluster.
// Each functional unit (FU) feeds a private 2-entry result FIFO. A
// round-robin arbiter picks one non-empty FIFO per cycle and loads the
// winner into a single output register that presents the writeback.
//
// Handshakes:
//   FU side : fu_done_i[k] is a one-cycle pulse. fu_wb_rdy_o[k] means "FIFO k
//             has space" and comes from registered state only. A pulse that
//             arrives while FIFO k is full is dropped and sets the sticky
//             wb_ovf_o flag.
//   WB side : the entry transfers when wb_vld_o & wb_rdy_i are both high.
//             While wb_vld_o=1 and wb_rdy_i=0 all wb_* outputs stay stable.
module mrv1_wb_arb #(
  parameter int NUM_TW_P     = 8,
  parameter int DATA_WIDTH_P = 32,
  parameter int ITAG_WIDTH_P = 3,
  parameter int NUM_FU_P     = 6,
  localparam int TID_W       = $clog2(NUM_TW_P),
  localparam int FU_W        = $clog2(NUM_FU_P)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_FU_P-1:0]              fu_done_i,
  input  logic [NUM_FU_P*DATA_WIDTH_P-1:0] fu_res_data_i,
  input  logic [NUM_FU_P*ITAG_WIDTH_P-1:0] fu_itag_i,
  input  logic [NUM_FU_P*TID_W-1:0]        fu_tid_i,
  output logic [NUM_FU_P-1:0]              fu_wb_rdy_o,
  output logic                             wb_vld_o,
  input  logic                             wb_rdy_i,
  output logic [DATA_WIDTH_P-1:0]          wb_data_o,
  output logic [ITAG_WIDTH_P-1:0]          wb_itag_o,
  output logic [TID_W-1:0]                 wb_tid_o,
  output logic [FU_W-1:0]                  wb_fu_o,
  output logic                             wb_ovf_o
);

  // Per-FU FIFO status and head-of-queue views.
  logic [NUM_FU_P-1:0]                   full;
  logic [NUM_FU_P-1:0]                   nonempty;
  logic [NUM_FU_P-1:0]                   push;
  logic [NUM_FU_P-1:0]                   pop;
  logic [NUM_FU_P-1:0][DATA_WIDTH_P-1:0] head_data;
  logic [NUM_FU_P-1:0][ITAG_WIDTH_P-1:0] head_itag;
  logic [NUM_FU_P-1:0][TID_W-1:0]        head_tid;

  // Arbiter state and decisions.
  logic [FU_W-1:0] rr_ptr;
  logic [FU_W-1:0] grant_idx;
  logic            grant_vld;
  logic            load;
  logic            ovf_evt;
  int              arb_idx;

  // Full-state backpressure: decided purely from registered counts so there
  // is no combinational path from wb_rdy_i to the FUs.
  assign fu_wb_rdy_o = ~full;

  // A pulse into a full FIFO is lost even if that FIFO pops this cycle.
  assign ovf_evt = |(fu_done_i & full);

  // The output register refills when it is empty or draining this cycle.
  assign load = grant_vld & (~wb_vld_o | wb_rdy_i);

  for (genvar k = 0; k < NUM_FU_P; k++) begin : g_fu
    logic [DATA_WIDTH_P-1:0] mem_data [2];
    logic [ITAG_WIDTH_P-1:0] mem_itag [2];
    logic [TID_W-1:0]        mem_tid  [2];
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [1:0]              cnt;

    assign full[k]      = (cnt == 2'd2);
    assign nonempty[k]  = (cnt != 2'd0);
    assign push[k]      = fu_done_i[k] & ~full[k];
    assign pop[k]       = load & (grant_idx == FU_W'(k));
    assign head_data[k] = mem_data[rd_ptr];
    assign head_itag[k] = mem_itag[rd_ptr];
    assign head_tid[k]  = mem_tid[rd_ptr];

    // FIFO pointers and occupancy; push and pop together leave cnt unchanged.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        cnt    <= 2'd0;
      end else begin
        if (push[k]) wr_ptr <= ~wr_ptr;
        if (pop[k])  rd_ptr <= ~rd_ptr;
        cnt <= cnt + {1'b0, push[k]} - {1'b0, pop[k]};
      end
    end

    // FIFO storage; contents are meaningless until cnt says otherwise.
    always_ff @(posedge clk_i) begin
      if (push[k]) begin
        mem_data[wr_ptr] <= fu_res_data_i[k*DATA_WIDTH_P +: DATA_WIDTH_P];
        mem_itag[wr_ptr] <= fu_itag_i[k*ITAG_WIDTH_P +: ITAG_WIDTH_P];
        mem_tid[wr_ptr]  <= fu_tid_i[k*TID_W +: TID_W];
      end
    end
  end

  // Round-robin pick: first non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int i = 0; i < NUM_FU_P; i++) begin
      arb_idx = (int'(rr_ptr) + i) % NUM_FU_P;
      if (!grant_vld && nonempty[arb_idx]) begin
        grant_vld = 1'b1;
        grant_idx = FU_W'(arb_idx);
      end
    end
  end

  // Output register, round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_vld_o  <= 1'b0;
      wb_data_o <= '0;
      wb_itag_o <= '0;
      wb_tid_o  <= '0;
      wb_fu_o   <= '0;
      wb_ovf_o  <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (load) begin
        wb_vld_o  <= 1'b1;
        wb_data_o <= head_data[grant_idx];
        wb_itag_o <= head_itag[grant_idx];
        wb_tid_o  <= head_tid[grant_idx];
        wb_fu_o   <= grant_idx;
        rr_ptr    <= (grant_idx == FU_W'(NUM_FU_P - 1)) ? '0 : grant_idx + 1'b1;
      end else if (wb_rdy_i) begin
        wb_vld_o <= 1'b0;
      end
      if (ovf_evt) wb_ovf_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mrv1_wb_arb.sv
// Directed bench for mrv1_wb_arb. Expected writebacks are queued as the
// stimulus is driven; a monitor pops and compares on every handshake.
module tb_mrv1_wb_arb;
  localparam int NFU = 6;
  localparam int DW  = 32;
  localparam int IW  = 3;
  localparam int TW  = 3;
  localparam int FW  = 3;
  localparam int EW  = FW + TW + IW + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NFU-1:0]    fu_done;
  logic [NFU*DW-1:0] fu_data;
  logic [NFU*IW-1:0] fu_itag;
  logic [NFU*TW-1:0] fu_tid;
  logic [NFU-1:0]    fu_wb_rdy;
  logic              wb_vld;
  logic              wb_rdy;
  logic [DW-1:0]     wb_data;
  logic [IW-1:0]     wb_itag;
  logic [TW-1:0]     wb_tid;
  logic [FW-1:0]     wb_fu;
  logic              wb_ovf;

  logic [EW-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  mrv1_wb_arb dut (
    .clk_i(clk), .rst_i(rst), .fu_done_i(fu_done), .fu_res_data_i(fu_data),
    .fu_itag_i(fu_itag), .fu_tid_i(fu_tid), .fu_wb_rdy_o(fu_wb_rdy),
    .wb_vld_o(wb_vld), .wb_rdy_i(wb_rdy), .wb_data_o(wb_data),
    .wb_itag_o(wb_itag), .wb_tid_o(wb_tid), .wb_fu_o(wb_fu), .wb_ovf_o(wb_ovf)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Scoreboard: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && wb_vld && wb_rdy) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {wb_fu, wb_data}, 64'hffff_ffff_ffff_ffff);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("wb_fu",   64'(wb_fu),   64'(e[EW-1 -: FW]));
        chk("wb_tid",  64'(wb_tid),  64'(e[IW+DW +: TW]));
        chk("wb_itag", 64'(wb_itag), 64'(e[DW +: IW]));
        chk("wb_data", 64'(wb_data), 64'(e[DW-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm one FU pulse for the current cycle; optionally record the expectation.
  task automatic set_fu(input int k, input logic [DW-1:0] d, input logic [IW-1:0] it,
                        input logic [TW-1:0] t, input bit expect_it);
    fu_done[k]          = 1'b1;
    fu_data[k*DW +: DW] = d;
    fu_itag[k*IW +: IW] = it;
    fu_tid[k*TW +: TW]  = t;
    if (expect_it) exp_q.push_back({FW'(k), t, it, d});
  endtask

  task automatic clr_fu();
    fu_done = '0;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || wb_vld) && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 64'(k < 100), 64'd1);
  endtask

  initial begin
    rst = 1'b1; wb_rdy = 1'b0; fu_done = '0; fu_data = '0; fu_itag = '0; fu_tid = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_vld",  64'(wb_vld),    64'd0);
    chk("rst_ovf",  64'(wb_ovf),    64'd0);
    chk("rst_data", 64'(wb_data),   64'd0);
    chk("rst_fu",   64'(wb_fu),     64'd0);
    chk("rst_rdy",  64'(fu_wb_rdy), 64'h3f);

    // Latency: pulse in cycle 10, valid in cycle 12.
    wb_rdy = 1'b1;
    while (cyc < 10) tick();
    set_fu(2, 32'hDEADBEEF, 3'd5, 3'd3, 1'b1);
    tick(); clr_fu();
    chk("lat_c11_vld", 64'(wb_vld), 64'd0);
    tick();
    chk("lat_cyc",  64'(cyc),     64'd12);
    chk("lat_vld",  64'(wb_vld),  64'd1);
    chk("lat_data", 64'(wb_data), 64'hDEADBEEF);
    chk("lat_itag", 64'(wb_itag), 64'd5);
    chk("lat_tid",  64'(wb_tid),  64'd3);
    chk("lat_fu",   64'(wb_fu),   64'd2);
    wait_drain("lat_drain");

    // Reset brings the round-robin pointer back to 0.
    rst = 1'b1; tick(); rst = 1'b0;

    // Fairness: two rounds of all-FU pulses, granted 0..5 each time.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NFU; k++) set_fu(k, 32'h100 * (r + 1) + k, IW'(k), TW'(k + r), 1'b1);
      tick(); clr_fu();
      tick();
      for (int i = 0; i < NFU; i++) begin
        chk("fair_fu", 64'(wb_fu), 64'(i));
        tick();
      end
      wait_drain("fair_drain");
    end

    // Rotation: after an FU4 grant the pointer sits at 5, so FU5 beats FU0.
    set_fu(4, 32'h44, 3'd4, 3'd4, 1'b1);
    tick(); clr_fu();
    wait_drain("rot_drain4");
    set_fu(0, 32'h50, 3'd0, 3'd1, 1'b0);
    set_fu(5, 32'h55, 3'd5, 3'd2, 1'b0);
    exp_q.push_back({3'd5, 3'd2, 3'd5, 32'h55});
    exp_q.push_back({3'd0, 3'd1, 3'd0, 32'h50});
    tick(); clr_fu();
    tick();
    chk("rot_first", 64'(wb_fu), 64'd5);
    wait_drain("rot_drain");

    // Stall: output holds 0x11 while FU1's FIFO fills to two entries.
    wb_rdy = 1'b0;
    set_fu(1, 32'h11, 3'd1, 3'd1, 1'b1); tick(); clr_fu();
    set_fu(1, 32'h22, 3'd2, 3'd1, 1'b1); tick(); clr_fu();
    set_fu(1, 32'h33, 3'd3, 3'd1, 1'b1); tick(); clr_fu();
    chk("stall_rdy",  64'(fu_wb_rdy), 64'h3d);
    chk("stall_vld",  64'(wb_vld),    64'd1);
    chk("stall_data", 64'(wb_data),   64'h11);
    tick(); tick(); tick();
    chk("stall_hold", 64'(wb_data),   64'h11);
    chk("stall_ovf",  64'(wb_ovf),    64'd0);
    wb_rdy = 1'b1;
    wait_drain("stall_drain");

    // Overflow: four back-to-back pulses with no drain; the fourth is lost.
    wb_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_fu(0, 32'hA1 + i, IW'(i), 3'd6, i < 3);
      tick(); clr_fu();
    end
    chk("ovf_set",  64'(wb_ovf),       64'd1);
    chk("ovf_full", 64'(fu_wb_rdy[0]), 64'd0);
    wb_rdy = 1'b1;
    wait_drain("ovf_drain");
    tick(); tick();
    chk("ovf_sticky", 64'(wb_ovf), 64'd1);
    chk("ovf_idle",   64'(wb_vld), 64'd0);

    // Reset mid-operation discards buffered results and the reset-cycle pulse.
    wb_rdy = 1'b0;
    set_fu(1, 32'hB1, 3'd1, 3'd1, 1'b0);
    set_fu(2, 32'hB2, 3'd2, 3'd2, 1'b0);
    set_fu(3, 32'hB3, 3'd3, 3'd3, 1'b0);
    tick(); clr_fu();
    tick();
    rst = 1'b1;
    set_fu(4, 32'hB4, 3'd4, 3'd4, 1'b0);
    tick(); clr_fu();
    rst = 1'b0;
    chk("mrst_vld", 64'(wb_vld),    64'd0);
    chk("mrst_ovf", 64'(wb_ovf),    64'd0);
    chk("mrst_rdy", 64'(fu_wb_rdy), 64'h3f);
    wb_rdy = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mrst_quiet", 64'(wb_vld), 64'd0);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
